// File: rtl/nco_freq_meter.sv
// nco_freq_meter: counts synchronized rising edges of sig_in over a gate of
// 2^G clocks and reports the count scaled to the FCW an N-bit nco would need.
module nco_freq_meter #(
  parameter int N = 16,
  parameter int G = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         sig_in,
  input  logic         start,
  input  logic         continuous,
  output logic [N-1:0] fcw,
  output logic         valid,
  output logic         busy
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    GATE   = 2'd2
  } state_t;

  localparam int             SHIFT       = N - G;
  localparam logic [1:0]     SETTLE_LAST = 2'd2;
  localparam logic [G-1:0]   GATE_LAST   = {G{1'b1}};
  localparam logic [G-1:0]   G_ZERO      = {G{1'b0}};

  state_t         state_r;
  state_t         state_nx_s;
  logic           s1_r;
  logic           s2_r;
  logic           s3_r;
  logic           rise_s;
  logic           start_r;
  logic [1:0]     settle_cnt_r;
  logic [G-1:0]   gate_cnt_r;
  logic [G-1:0]   edge_cnt_r;
  logic           settle_last_s;
  logic           gate_last_s;
  logic [N-1:0]   fcw_r;
  logic [N-1:0]   fcw_nx_s;
  logic           valid_r;
  logic           valid_nx_s;
  logic           busy_r;
  logic           busy_nx_s;

  // The final gate cycle's own rise is folded in; the sum never exceeds 2^(G-1).
  function automatic logic [N-1:0] scale_count(input logic [G-1:0] cnt, input logic inc);
    logic [N-1:0] sum;
    sum = N'(cnt) + N'(inc);
    return sum << SHIFT;
  endfunction

  assign rise_s        = s2_r & ~s3_r;
  assign settle_last_s = (state_r == SETTLE) && (settle_cnt_r == SETTLE_LAST);
  assign gate_last_s   = (state_r == GATE) && (gate_cnt_r == GATE_LAST);

  // Input synchronizer, launch request capture and gate/edge counters
  always_ff @(posedge clk) begin
    if (reset) begin
      s1_r         <= 1'b0;
      s2_r         <= 1'b0;
      s3_r         <= 1'b0;
      start_r      <= 1'b0;
      settle_cnt_r <= 2'd0;
      gate_cnt_r   <= G_ZERO;
      edge_cnt_r   <= G_ZERO;
    end else begin
      s1_r    <= sig_in;
      s2_r    <= s1_r;
      s3_r    <= s2_r;
      start_r <= start & (state_r == IDLE);
      if ((state_r == SETTLE) && !settle_last_s) begin
        settle_cnt_r <= settle_cnt_r + 2'd1;
      end else begin
        settle_cnt_r <= 2'd0;
      end
      if (state_r == GATE) begin
        gate_cnt_r <= gate_cnt_r + G'(1'b1);
        if (gate_last_s) begin
          edge_cnt_r <= G_ZERO;
        end else begin
          edge_cnt_r <= edge_cnt_r + G'(rise_s);
        end
      end else begin
        gate_cnt_r <= G_ZERO;
        edge_cnt_r <= G_ZERO;
      end
    end
  end

  // Measurement state register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nx_s;
    end
  end

  // Next-state logic
  always_comb begin
    state_nx_s = state_r;
    case (state_r)
      IDLE: begin
        if (start_r) begin
          state_nx_s = SETTLE;
        end else begin
          state_nx_s = IDLE;
        end
      end
      SETTLE: begin
        if (settle_last_s) begin
          state_nx_s = GATE;
        end else begin
          state_nx_s = SETTLE;
        end
      end
      GATE: begin
        if (gate_last_s && !continuous) begin
          state_nx_s = IDLE;
        end else begin
          state_nx_s = GATE;
        end
      end
      default: begin
        state_nx_s = IDLE;
      end
    endcase
  end

  // Output next values; fcw holds its last result between gates
  always_comb begin
    valid_nx_s = 1'b0;
    fcw_nx_s   = fcw_r;
    busy_nx_s  = (state_nx_s != IDLE);
    if (gate_last_s) begin
      valid_nx_s = 1'b1;
      fcw_nx_s   = scale_count(edge_cnt_r, rise_s);
    end else begin
      valid_nx_s = 1'b0;
      fcw_nx_s   = fcw_r;
    end
  end

  // Output registers
  always_ff @(posedge clk) begin
    if (reset) begin
      fcw_r   <= {N{1'b0}};
      valid_r <= 1'b0;
      busy_r  <= 1'b0;
    end else begin
      fcw_r   <= fcw_nx_s;
      valid_r <= valid_nx_s;
      busy_r  <= busy_nx_s;
    end
  end

  assign fcw   = fcw_r;
  assign valid = valid_r;
  assign busy  = busy_r;

endmodule

// File: tb/tb_nco_freq_meter.sv
// Bench for nco_freq_meter: phase-accumulator stimulus, expected results from
// counting rising edges of the recorded input over each gate window.
module tb_nco_freq_meter;

  localparam int N        = 16;
  localparam int G        = 8;
  localparam int GATE_LEN = 1 << G;
  localparam int HIST     = 32768;

  logic         clk = 1'b0;
  logic         reset;
  logic         sig_in = 1'b0;
  logic         start;
  logic         continuous;
  logic [N-1:0] fcw;
  logic         valid;
  logic         busy;
  logic         start1;
  logic         cont1;
  logic [N-1:0] fcw1;
  logic         valid1;
  logic         busy1;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  bit hist [HIST];

  int          gen_mode  = 1;
  logic        gen_lvl   = 1'b0;
  logic [15:0] gen_inc   = 16'd32768;
  logic [15:0] gen_ph    = 16'd0;
  bit          gen_guard = 1'b0;
  int          launch    = 0;

  nco_freq_meter #(.N(N), .G(G)) dut (
    .clk(clk), .reset(reset), .sig_in(sig_in), .start(start),
    .continuous(continuous), .fcw(fcw), .valid(valid), .busy(busy)
  );

  nco_freq_meter #(.N(N), .G(1)) dut1 (
    .clk(clk), .reset(reset), .sig_in(sig_in), .start(start1),
    .continuous(cont1), .fcw(fcw1), .valid(valid1), .busy(busy1)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Stimulus generator: value driven now is captured at edge cyc+1. With the
  // guard on, sig_in is frozen near gate boundaries so window edges are unambiguous.
  always @(negedge clk) begin : gen
    logic nxt;
    int   rel;
    if (gen_mode == 0) begin
      nxt = gen_lvl;
    end else begin
      gen_ph = gen_ph + gen_inc;
      nxt    = gen_ph[15];
    end
    rel = cyc + 1 - launch;
    if (gen_guard && rel >= 0 && ((rel % GATE_LEN) >= GATE_LEN - 3 || (rel % GATE_LEN) <= 5))
      nxt = sig_in;
    sig_in = nxt;
    if (cyc + 1 < HIST) hist[cyc + 1] = nxt;
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Reference: rising edges of sig_in as captured at edges a..b.
  function automatic int rises(input int a, input int b);
    int c = 0;
    for (int k = a; k <= b; k++)
      if (k >= 1 && k < HIST && hist[k] && !hist[k - 1]) c++;
    return c;
  endfunction

  task automatic launch_dut(output int l);
    @(negedge clk);
    start  = 1'b1;
    l      = cyc + 1;
    launch = l;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_valid(input int limit, output int at, output logic [N-1:0] val);
    bit found = 1'b0;
    at  = -1;
    val = '0;
    for (int i = 0; i < limit && !found; i++) begin
      @(negedge clk);
      if (valid === 1'b1) begin
        found = 1'b1;
        at    = cyc;
        val   = fcw;
      end
    end
    check_val("valid_seen", 32'(found), 32'd1);
  endtask

  task automatic count_valid(input int n, output int c);
    c = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (valid === 1'b1) c++;
    end
  endtask

  task automatic one_shot(input string tag);
    int l;
    int at;
    logic [N-1:0] val;
    launch_dut(l);
    check_val({tag, "_busy_at_start_edge"}, 32'(busy), 32'd0);
    @(negedge clk);
    check_val({tag, "_busy_edge1"}, 32'(busy), 32'd1);
    wait_valid(400, at, val);
    check_val({tag, "_latency"}, 32'(at - l), 32'(GATE_LEN + 4));
    check_val({tag, "_fcw"}, 32'(val), 32'(rises(l + 1, l + GATE_LEN) << (N - G)));
    check_val({tag, "_busy_done"}, 32'(busy), 32'd0);
    @(negedge clk);
    check_val({tag, "_valid_one_cycle"}, 32'(valid), 32'd0);
  endtask

  task automatic run_cont(input string tag, input int gates, output int sum);
    int l;
    int at;
    logic [N-1:0] val;
    sum = 0;
    continuous = 1'b1;
    launch_dut(l);
    for (int g = 0; g < gates; g++) begin
      wait_valid(400, at, val);
      check_val({tag, "_spacing"}, 32'(at - l), 32'(GATE_LEN + 4 + GATE_LEN * g));
      check_val({tag, "_fcw"}, 32'(val),
                32'(rises(l + 1 + GATE_LEN * g, l + GATE_LEN * (g + 1)) << (N - G)));
      check_val({tag, "_busy"}, 32'(busy), (g == gates - 1) ? 32'd0 : 32'd1);
      sum += int'(val);
      if (g == gates - 2) continuous = 1'b0;
    end
  endtask

  initial begin
    int l;
    int cnt;
    int sum;
    int at;
    reset = 1'b1; start = 1'b0; continuous = 1'b0; start1 = 1'b0; cont1 = 1'b0;

    // Reset with sig_in toggling
    repeat (2) @(negedge clk);
    reset = 1'b0;
    check_val("reset_fcw", 32'(fcw), 32'd0);
    check_val("reset_valid", 32'(valid), 32'd0);
    check_val("reset_busy", 32'(busy), 32'd0);
    count_valid(50, cnt);
    check_val("no_valid_without_start", 32'(cnt), 32'd0);

    // Period-8, fastest toggle, constant high
    gen_inc = 16'd8192;
    one_shot("period8");
    gen_inc = 16'd32768;
    one_shot("toggle");
    gen_mode = 0; gen_lvl = 1'b1;
    one_shot("const_high");
    gen_mode = 1;

    // start pulses during GATE are ignored
    gen_inc = 16'd8192;
    launch_dut(l);
    while (cyc < l + 100) @(negedge clk);
    start = 1'b1; @(negedge clk); start = 1'b0;
    while (cyc < l + 150) @(negedge clk);
    start = 1'b1; @(negedge clk); start = 1'b0;
    cnt = 0;
    while (cyc < l + 600) begin
      @(negedge clk);
      if (valid === 1'b1) cnt++;
    end
    check_val("one_valid_per_launch", 32'(cnt), 32'd1);
    check_val("ignored_start_fcw", 32'(fcw), 32'(rises(l + 1, l + GATE_LEN) << (N - G)));

    // Reset at gate cycle 100
    launch_dut(l);
    while (cyc < l + 104) @(negedge clk);
    reset = 1'b1; @(negedge clk); reset = 1'b0;
    check_val("midreset_busy", 32'(busy), 32'd0);
    check_val("midreset_fcw", 32'(fcw), 32'd0);
    check_val("midreset_valid", 32'(valid), 32'd0);
    count_valid(300, cnt);
    check_val("midreset_no_valid", 32'(cnt), 32'd0);
    gen_inc = 16'($urandom_range(32767, 1)); gen_guard = 1'b1;
    one_shot("after_reset_rand");
    gen_guard = 1'b0;

    // Loopback from an nco at fcw 4096, continuous
    gen_inc = 16'd4096;
    run_cont("loopback", 16, sum);
    check_val("loopback_mean", 32'(sum / 16), 32'd4096);

    // Randomized rates in continuous mode
    gen_guard = 1'b1;
    for (int r = 0; r < 3; r++) begin
      gen_inc = 16'($urandom_range(32767, 1));
      run_cont("rand_cont", 4, sum);
    end
    gen_guard = 1'b0;

    // G=1 boundary, period-2 input
    gen_inc = 16'd32768;
    @(negedge clk); start1 = 1'b1; l = cyc + 1; launch = l;
    @(negedge clk); start1 = 1'b0;
    at = -1;
    for (int i = 0; i < 20 && at < 0; i++) begin
      @(negedge clk);
      if (valid1 === 1'b1) at = cyc;
    end
    check_val("g1_latency", 32'(at - l), 32'd6);
    check_val("g1_fcw", 32'(fcw1), 32'(rises(l + 1, l + 2) << (N - 1)));
    check_val("g1_busy_done", 32'(busy1), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
